bf_out_sched: RTL and testbench
===============================

// Module: bf_out_sched
// PURPOSE
//  Stage/cycle scheduler for the dual-butterfly NTT core and its output crossbar.
//  On start, runs num_stages passes over an N-point polynomial, issuing one 4-coefficient group per cycle.
//  Drives radix mode sel_0 and crossbar selects sel_a_0..3 at issue time; the crossbar applies its own 10/12-cycle delay.
//  Produces out_valid aligned to crossbar output, inserts a pipeline drain between stages, and pulses done at the end.
// PARAMETERS
//  N_LOG2  8   log2 of transform length; cycles per stage CPS = 2^(N_LOG2-2)
//  LAT_R2  10  butterfly+crossbar latency in radix-2 mode (sel_0=0)
//  LAT_R4  12  butterfly+crossbar latency in radix-4 mode (sel_0=1)
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous reset, active-high
//  start       in   1       1-cycle request; accepted only in IDLE
//  radix4      in   1       mode, sampled with start: 0 = radix-2, 1 = radix-4
//  num_stages  in   4       stage count, sampled with start
//  stall       in   1       issue hold (only with BF_SCHED_STALL_EN)
//  busy        out  1       high from cycle after accepted start through DONE
//  done        out  1       1-cycle completion pulse
//  issue       out  1       butterfly input group valid this cycle
//  sel_0       out  1       latched radix4, held constant for whole run
//  sel_a_0..3  out  2 each  crossbar select per output lane, valid when issue=1
//  stage_idx   out  4       current stage number, 0-based
//  out_valid   out  1       crossbar output d0..d3 valid this cycle
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; counters 0; delay line cleared. Reset mid-run aborts immediately with no done.
//  - FSM states:
//    - IDLE: start=1 latches radix4/num_stages. num_stages=0 -> DONE, else -> ISSUE.
//    - ISSUE: issue=1 every unstalled cycle; grp counter 0..CPS-1. Last group -> DRAIN.
//    - DRAIN: counts LAT cycles (LAT_R2 or LAT_R4 per latched mode). Then stage_idx+1; if stage_idx+1==num_stages -> DONE, else -> ISSUE.
//    - DONE: done=1 for one cycle -> IDLE.
//  - start while not IDLE is ignored; no queuing.
//  - Select pattern (lanes 0..3), same for both radix modes:
//    - stage_idx even, straight: {01,00,11,10} = {bf0_up, bf0_lo, bf1_up, bf1_lo}
//    - stage_idx odd, interleaved: {01,11,00,10} = {bf0_up, bf1_up, bf0_lo, bf1_lo}
//    - sel_a_* = 00 whenever issue=0.
//  - out_valid is issue delayed through a shift line of depth LAT (LAT_R2 or LAT_R4 per latched sel_0).
//  - Last out_valid of a stage occurs on the final DRAIN cycle; none outside a run.
//  - Counter widths: grp N_LOG2-2 bits, drain counter 4 bits. Wrap is never relied on; terminal compares are explicit.
// CONFIGURATION
//  - BF_SCHED_STALL_EN defined:
//    - stall port exists. stall=1 in ISSUE suppresses issue; grp and sel hold; FSM stays.
//    - DRAIN, DONE and the delay line are unaffected by stall.
//  - BF_SCHED_STALL_EN undefined: stall port absent, behaviour identical to stall tied 0.
// TESTING (N_LOG2=4, CPS=4; start asserted at cycle 0)
//  1. radix4=0, num_stages=2 -> issue cyc 1-4 and 15-18; out_valid 11-14 and 25-28.
//     Continued: sel_a {01,00,11,10} in stage 0, {01,11,00,10} in stage 1; done at cyc 29; busy 1-29.
//  2. radix4=1, num_stages=1 -> sel_0=1 from cyc 1; issue 1-4; out_valid 13-16; done at 17.
//  3. num_stages=0 -> done=1 at cyc 1; issue and out_valid never high.
//  4. Second start at cyc 3 during run of test 1 -> ignored; timing identical to test 1.
//  5. rst at cyc 8 of test 1 -> all outputs 0 at cyc 8; no done.
//     Then: a new start at cyc 10 runs cleanly with out_valid first at cyc 21.
//  6. BF_SCHED_STALL_EN, test 2 with stall=1 at cyc 2-3 -> issue at 1,4,5,6; out_valid 13,16,17,18; done at 19.

Source files
------------

// File: rtl/bf_out_sched.sv
// Stage/cycle scheduler for the dual-butterfly NTT core and its output crossbar.
// Optional issue stall port enabled by defining BF_SCHED_STALL_EN.
module bf_out_sched #(
    parameter int N_LOG2 = 8,
    parameter int LAT_R2 = 10,
    parameter int LAT_R4 = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       radix4,
    input  logic [3:0] num_stages,
`ifdef BF_SCHED_STALL_EN
    input  logic       stall,
`endif
    output logic       busy,
    output logic       done,
    output logic       issue,
    output logic       sel_0,
    output logic [1:0] sel_a_0,
    output logic [1:0] sel_a_1,
    output logic [1:0] sel_a_2,
    output logic [1:0] sel_a_3,
    output logic [3:0] stage_idx,
    output logic       out_valid
);

    localparam int GW = N_LOG2 - 2;
    localparam logic [GW-1:0] GRP_LAST = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     grp_q, grp_d;
    logic [3:0]        drain_q, drain_d;
    logic [3:0]        stage_q, stage_d;
    logic [3:0]        nstg_q, nstg_d;
    logic              sel0_q, sel0_d;
    logic [LAT_R4-1:0] dly_q, dly_d;

    logic       stall_w;
    logic       issue_w;
    logic [3:0] lat_last;
    logic [4:0] stage_next;

`ifdef BF_SCHED_STALL_EN
    assign stall_w = stall;
`else
    assign stall_w = 1'b0;
`endif

    assign issue_w    = (state_q == S_ISSUE) && !stall_w;
    assign lat_last   = sel0_q ? 4'(LAT_R4 - 1) : 4'(LAT_R2 - 1);
    assign stage_next = {1'b0, stage_q} + 5'd1;

    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        drain_d = drain_q;
        stage_d = stage_q;
        nstg_d  = nstg_q;
        sel0_d  = sel0_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel0_d  = radix4;
                    nstg_d  = num_stages;
                    stage_d = 4'd0;
                    grp_d   = '0;
                    drain_d = 4'd0;
                    state_d = (num_stages == 4'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!stall_w) begin
                    if (grp_q == GRP_LAST) begin
                        grp_d   = '0;
                        drain_d = 4'd0;
                        state_d = S_DRAIN;
                    end else begin
                        grp_d = grp_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Drain lasts exactly LAT cycles so the stage's last out_valid lands on its final cycle
                if (drain_q == lat_last) begin
                    drain_d = 4'd0;
                    stage_d = stage_next[3:0];
                    state_d = (stage_next == {1'b0, nstg_q}) ? S_DONE : S_ISSUE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        sel_a_0 = 2'b00;
        sel_a_1 = 2'b00;
        sel_a_2 = 2'b00;
        sel_a_3 = 2'b00;
        if (issue_w) begin
            sel_a_0 = 2'b01;
            sel_a_3 = 2'b10;
            if (stage_q[0]) begin
                sel_a_1 = 2'b11;
                sel_a_2 = 2'b00;
            end else begin
                sel_a_1 = 2'b00;
                sel_a_2 = 2'b11;
            end
        end
    end

    // The delay line is sized for the longer mode and tapped per latched mode
    assign dly_d = {dly_q[LAT_R4-2:0], issue_w};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            grp_q   <= '0;
            drain_q <= 4'd0;
            stage_q <= 4'd0;
            nstg_q  <= 4'd0;
            sel0_q  <= 1'b0;
            dly_q   <= '0;
        end else begin
            state_q <= state_d;
            grp_q   <= grp_d;
            drain_q <= drain_d;
            stage_q <= stage_d;
            nstg_q  <= nstg_d;
            sel0_q  <= sel0_d;
            dly_q   <= dly_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign issue     = issue_w;
    assign sel_0     = sel0_q;
    assign stage_idx = stage_q;
    assign out_valid = sel0_q ? dly_q[LAT_R4-1] : dly_q[LAT_R2-1];

endmodule

// File: tb/tb_bf_out_sched.sv
// Directed self-checking bench for bf_out_sched with N_LOG2=4 (4 groups per stage).
// Cycle c begins at the c-th rising edge after a test starts; inputs change 1 time unit after it, outputs are sampled on the falling edge.
module tb_bf_out_sched;

    logic       clk;
    logic       rst;
    logic       start;
    logic       radix4;
    logic [3:0] num_stages;
    logic       stall;
    logic       busy;
    logic       done;
    logic       issue;
    logic       sel_0;
    logic [1:0] sel_a_0;
    logic [1:0] sel_a_1;
    logic [1:0] sel_a_2;
    logic [1:0] sel_a_3;
    logic [3:0] stage_idx;
    logic       out_valid;
    logic [7:0] sel_all;

    int checks;
    int passes;

    bf_out_sched #(.N_LOG2(4), .LAT_R2(10), .LAT_R4(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .radix4     (radix4),
        .num_stages (num_stages),
`ifdef BF_SCHED_STALL_EN
        .stall      (stall),
`endif
        .busy       (busy),
        .done       (done),
        .issue      (issue),
        .sel_0      (sel_0),
        .sel_a_0    (sel_a_0),
        .sel_a_1    (sel_a_1),
        .sel_a_2    (sel_a_2),
        .sel_a_3    (sel_a_3),
        .stage_idx  (stage_idx),
        .out_valid  (out_valid)
    );

    assign sel_all = {sel_a_0, sel_a_1, sel_a_2, sel_a_3};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        radix4 = 1'b0;
        num_stages = 4'd0;
        stall = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, issue, sel_0, sel_all, stage_idx, out_valid} !== 17'd0)
            $display("[TB] FAIL reset outputs got %b required 0",
                     {busy, done, issue, sel_0, sel_all, stage_idx, out_valid});
        else passes++;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Two-stage radix-2 run; optionally a conflicting start at cycle 3 that must be ignored
    task automatic run_two_stage(input string tag, input bit extra_start);
        bit         e_iss, e_ov, e_done, e_busy;
        logic [7:0] e_sel;
        for (int c = 0; c <= 32; c++) begin
            @(posedge clk); #1;
            start      = (c == 0) || (extra_start && c == 3);
            radix4     = extra_start && (c == 3);
            num_stages = (c == 3) ? 4'd5 : 4'd2;
            @(negedge clk);
            if (c >= 1) begin
                e_iss  = (c >= 1 && c <= 4) || (c >= 15 && c <= 18);
                e_ov   = (c >= 11 && c <= 14) || (c >= 25 && c <= 28);
                e_done = (c == 29);
                e_busy = (c >= 1 && c <= 29);
                e_sel  = !e_iss ? 8'h00 : (c <= 4) ? 8'b01_00_11_10 : 8'b01_11_00_10;
                checks++;
                if (issue !== e_iss) $display("[TB] FAIL %s issue c=%0d got %b required %b", tag, c, issue, e_iss);
                else passes++;
                checks++;
                if (out_valid !== e_ov) $display("[TB] FAIL %s out_valid c=%0d got %b required %b", tag, c, out_valid, e_ov);
                else passes++;
                checks++;
                if (done !== e_done) $display("[TB] FAIL %s done c=%0d got %b required %b", tag, c, done, e_done);
                else passes++;
                checks++;
                if (busy !== e_busy) $display("[TB] FAIL %s busy c=%0d got %b required %b", tag, c, busy, e_busy);
                else passes++;
                checks++;
                if (sel_all !== e_sel) $display("[TB] FAIL %s sel_a c=%0d got %b required %b", tag, c, sel_all, e_sel);
                else passes++;
                checks++;
                if (sel_0 !== 1'b0) $display("[TB] FAIL %s sel_0 c=%0d got %b required 0", tag, c, sel_0);
                else passes++;
                if (e_iss) begin
                    checks++;
                    if (stage_idx !== ((c <= 4) ? 4'd0 : 4'd1))
                        $display("[TB] FAIL %s stage_idx c=%0d got %0d required %0d", tag, c, stage_idx, (c <= 4) ? 0 : 1);
                    else passes++;
                end
            end
        end
        start = 1'b0;
        radix4 = 1'b0;
    endtask

    task automatic test_radix2();
        run_two_stage("radix2", 1'b0);
    endtask

    task automatic test_ignore_start();
        run_two_stage("ignore_start", 1'b1);
    endtask

    task automatic test_radix4();
        bit e_iss, e_ov, e_done;
        for (int c = 0; c <= 20; c++) begin
            @(posedge clk); #1;
            start      = (c == 0);
            radix4     = 1'b1;
            num_stages = 4'd1;
            @(negedge clk);
            if (c >= 1) begin
                e_iss  = (c >= 1 && c <= 4);
                e_ov   = (c >= 13 && c <= 16);
                e_done = (c == 17);
                checks++;
                if (issue !== e_iss) $display("[TB] FAIL radix4 issue c=%0d got %b required %b", c, issue, e_iss);
                else passes++;
                checks++;
                if (out_valid !== e_ov) $display("[TB] FAIL radix4 out_valid c=%0d got %b required %b", c, out_valid, e_ov);
                else passes++;
                checks++;
                if (done !== e_done) $display("[TB] FAIL radix4 done c=%0d got %b required %b", c, done, e_done);
                else passes++;
                checks++;
                if (sel_0 !== 1'b1) $display("[TB] FAIL radix4 sel_0 c=%0d got %b required 1", c, sel_0);
                else passes++;
            end
        end
        start = 1'b0;
        radix4 = 1'b0;
    endtask

    task automatic test_zero_stages();
        for (int c = 0; c <= 16; c++) begin
            @(posedge clk); #1;
            start      = (c == 0);
            num_stages = 4'd0;
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (done !== (c == 1)) $display("[TB] FAIL zero_stages done c=%0d got %b required %b", c, done, (c == 1));
                else passes++;
                checks++;
                if (busy !== (c == 1)) $display("[TB] FAIL zero_stages busy c=%0d got %b required %b", c, busy, (c == 1));
                else passes++;
                checks++;
                if ({issue, out_valid} !== 2'b00) $display("[TB] FAIL zero_stages issue/out_valid c=%0d got %b required 00", c, {issue, out_valid});
                else passes++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit e_ov;
        for (int c = 0; c <= 40; c++) begin
            @(posedge clk); #1;
            rst        = (c == 8);
            start      = (c == 0) || (c == 10);
            radix4     = 1'b0;
            num_stages = 4'd2;
            @(negedge clk);
            if (c == 8) begin
                checks++;
                if ({busy, done, issue, sel_0, sel_all, stage_idx, out_valid} !== 17'd0)
                    $display("[TB] FAIL mid_reset outputs got %b required 0",
                             {busy, done, issue, sel_0, sel_all, stage_idx, out_valid});
                else passes++;
            end
            if (c >= 9) begin
                e_ov = (c >= 21 && c <= 24) || (c >= 35 && c <= 38);
                checks++;
                if (out_valid !== e_ov) $display("[TB] FAIL mid_reset out_valid c=%0d got %b required %b", c, out_valid, e_ov);
                else passes++;
                checks++;
                if (done !== (c == 39)) $display("[TB] FAIL mid_reset done c=%0d got %b required %b", c, done, (c == 39));
                else passes++;
            end
        end
        start = 1'b0;
        rst = 1'b0;
    endtask

`ifdef BF_SCHED_STALL_EN
    task automatic test_stall();
        bit e_iss, e_ov;
        for (int c = 0; c <= 22; c++) begin
            @(posedge clk); #1;
            start      = (c == 0);
            radix4     = 1'b1;
            num_stages = 4'd1;
            stall      = (c == 2) || (c == 3);
            @(negedge clk);
            if (c >= 1) begin
                e_iss = (c == 1) || (c >= 4 && c <= 6);
                e_ov  = (c == 13) || (c >= 16 && c <= 18);
                checks++;
                if (issue !== e_iss) $display("[TB] FAIL stall issue c=%0d got %b required %b", c, issue, e_iss);
                else passes++;
                checks++;
                if (out_valid !== e_ov) $display("[TB] FAIL stall out_valid c=%0d got %b required %b", c, out_valid, e_ov);
                else passes++;
                checks++;
                if (done !== (c == 19)) $display("[TB] FAIL stall done c=%0d got %b required %b", c, done, (c == 19));
                else passes++;
                if (c == 2 || c == 3) begin
                    checks++;
                    if (sel_all !== 8'h00) $display("[TB] FAIL stall sel_a c=%0d got %b required 0", c, sel_all);
                    else passes++;
                end
            end
        end
        start = 1'b0;
        stall = 1'b0;
    endtask
`endif

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_radix2();
        test_radix4();
        test_zero_stages();
        test_ignore_start();
        test_reset_mid_run();
`ifdef BF_SCHED_STALL_EN
        test_stall();
`endif
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
